uart_rx: RTL and testbench

//   Serial receiver; the receive-side counterpart of uart_tx. Samples an asynchronous
//   8N1 line (8 data bits, no parity, 1 stop bit; LSB first, idle high) and presents

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 20 ++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by both the receive and transmit sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 8;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single asynchronous level.
// Resets to 1 so an idle-high serial line does not present a false edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_ff;

    // Shift the async input through two flops to settle metastability
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ff <= 2'b11;
        else          r_ff <= {r_ff[0], i_async};
    end

    assign o_sync = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, 1 stop bit, idle-high line.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
// Each byte is sampled at mid-bit; data holds the last good byte, valid and
// frame_err are single-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_pin,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int TW = $clog2(256);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    uart_state_t          r_state, w_state_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [2:0]           r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_rx_prev;
    logic                 w_rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_nxt;
    logic                 r_perr, w_perr_nxt;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (rx_pin),
        .o_sync  (w_rx_s)
    );

    // Delayed copy of the synchronised line for falling-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rx_prev <= 1'b1;
        else          r_rx_prev <= w_rx_s;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    // Next-state and datapath update; strobes default low every cycle
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                // Edge, not level: a line stuck low never restarts reception
                if (r_rx_prev && !w_rx_s) w_state_nxt = START;
            end
            START: begin
                if (r_timer == HALF_LAST) begin
                    w_timer_nxt = '0;
                    w_idx_nxt   = '0;
                    // High at mid start bit means it was a glitch
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_timer == FULL_LAST) begin
                    w_timer_nxt        = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_idx_nxt          = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_timer == FULL_LAST) begin
                    w_timer_nxt = '0;
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a start bit right after the stop bit is caught
                if (r_timer == FULL_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit have an even count of ones
                        w_perr_nxt  = (^r_shift) ^ r_par;
`endif
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT = 8). Frames are driven bit by
// bit; each frame pushes its expected outcome into a queue that a monitor
// consumes whenever valid or frame_err strobes.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 79 + CPB;
`else
    localparam int LAT = 79;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_pin = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_pin    (rx_pin),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       ferr;
        logic       perr;
        time        t0;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         n_chk = 0, n_fail = 0;
    int         n_valid = 0, n_ferr = 0;
    logic       busy_seen = 1'b0;
    time        t_prev_valid = 0, t_last_valid = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_pin = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_pin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame and record what the receiver must report for it
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok);
        exp_t e;
        e.b    = b;
        e.ferr = !stop_v;
        e.perr = stop_v && !par_ok;
        e.t0   = $time;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_ok ? ^b : ~^b);
`endif
        drive_bit(stop_v);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
        chk("rst_perr", parity_err, 0);
`endif
    endtask

    // Monitor: match every strobe against the oldest expected frame
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (valid || frame_err) begin
            exp_t e;
            int   lat;
            chk("strobe_excl", {31'b0, valid & frame_err}, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {31'b0, valid}, {31'b0, frame_err} + 32'd2);
            end else begin
                e   = exp_q.pop_front();
                lat = int'(($time - e.t0) / 10);
                chk("kind", {31'b0, frame_err}, {31'b0, e.ferr});
                chk("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
                if (valid) begin
                    chk("data", data, e.b);
`ifdef UART_RX_PARITY_EN
                    chk("parity_err", parity_err, e.perr);
`endif
                    exp_data     = e.b;
                    n_valid++;
                    t_prev_valid = t_last_valid;
                    t_last_valid = $time;
                end else begin
                    chk("ferr_data_held", data, exp_data);
                    n_ferr++;
                end
            end
        end
    end

    initial begin
        int nv0, nf0;
        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        idle(10);

        // 1: good 0xA5
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(20);
        chk("t1_data", data, 8'hA5);
        chk("t1_ferr_cnt", n_ferr, 0);

        // 2: short glitch is rejected
        busy_seen = 1'b0;
        nv0 = n_valid;
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        chk("t2_busy_pulsed", busy_seen, 1);
        chk("t2_busy_idle", busy, 0);
        chk("t2_no_valid", n_valid - nv0, 0);
        chk("t2_data", data, 8'hA5);

        // 3: good 0x11 then framing error on 0x3C, line then held low
        send_frame(8'h11, 1'b1, 1'b1);
        idle(16);
        nf0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b1);
        rx_pin = 1'b0;
        repeat (40) @(negedge clk);
        chk("t3_ferr_cnt", n_ferr - nf0, 1);
        chk("t3_data", data, 8'h11);
        chk("t3_held_low_busy", busy, 0);
        idle(16);

        // 4: back-to-back frames, no idle bits
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(20);
        chk("t4_interval", int'((t_last_valid - t_prev_valid) / 10), 80 + (LAT - 79));
        chk("t4_data", data, 8'hFF);

        // 5: reset in the middle of 0x5A, then 0x81
        nv0 = n_valid;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'(8'h5A >> i));
        reset_n  = 1'b0;
        rx_pin   = 1'b1;
        exp_data = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        idle(16);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(20);
        chk("t5_one_valid", n_valid - nv0, 1);
        chk("t5_data", data, 8'h81);

`ifdef UART_RX_PARITY_EN
        // 6: parity mismatch still delivers the byte
        send_frame(8'h07, 1'b1, 1'b0);
        idle(16);
        chk("t6_data_bad_par", data, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(16);
`endif

        // Randomised frames, gaps, stop errors and glitches
        for (int k = 0; k < 40; k++) begin
            logic [7:0] b;
            logic       stop_v, par_ok;
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 5) != 0);
            par_ok = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_v, par_ok);
            if (!stop_v) idle(CPB + $urandom_range(0, 6));
            else if ($urandom_range(0, 7) == 0) begin
                idle(4);
                rx_pin = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                idle(12);
            end else idle($urandom_range(0, 10));
        end
        idle(200);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_data", data, exp_data);
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
